win_addr_gen: RTL and testbench
===============================

// Module: win_addr_gen
// PURPOSE
//  Parametrised window-sweep address generator for the conv datapath. On one start command it walks
//  every WINxWIN window over a square image held in DDR3, emitting one DDR word address per tap
//  (row-major taps, windows row-major) with a valid/ready handshake toward the DDR read requester.
//  Generalises the single-tap per-cycle address calculator: arbitrary window, word/pixel widths, stride.
// PARAMETERS
//  WIN       3     window edge (taps per window = WIN*WIN), 1..8
//  WORD_LEN  32    DDR3 word width in bits
//  PIX_BITS  2048  bits stored per pixel (all channels); WPP = PIX_BITS/WORD_LEN words per pixel
//  ADDR_W    28    DDR word-address width
//  EDGE_W    6     width of img_edge (image edge length minus 1)
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous reset, active high
//  start       in   1       start sweep; sampled only in IDLE
//  base_addr   in   ADDR_W  address of pixel (0,0); captured on start
//  img_edge    in   EDGE_W  image edge length minus 1; captured on start
//  addr        out  ADDR_W  tap address
//  addr_valid  out  1       addr is valid
//  addr_ready  in   1       consumer accepts addr this cycle
//  tap_last    out  1       qualifies addr: last tap of current window
//  busy        out  1       high from accepted start until done
//  done        out  1       one-cycle pulse at end of sweep
//  err         out  1       one-cycle pulse with done when image edge < WIN
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE; reset mid-sweep aborts without done.
//  - FSM: IDLE -start-> LOAD -> EMIT -last handshake-> DONE -> IDLE. LOAD -(img_edge+1<WIN)-> DONE w/ err.
//  - LOAD (1 cycle): register row_pitch = (img_edge+1)*WPP; win_base = base_addr. First addr_valid
//    two cycles after start sampled high.
//  - Address = base + ((r+dr)*(img_edge+1) + (c+dc))*WPP mod 2^ADDR_W; built incrementally from
//    win_base/row_pitch adders (no runtime multiply/divide; WPP is a power of two, a shift).
//  - Order: dc fastest, then dr, then window column c, then window row r. c,r step by STRIDE;
//    a window position is legal while c+WIN <= img_edge+1 (same for r).
//  - Handshake: transfer when addr_valid & addr_ready; addr/tap_last held stable while
//    valid & !ready; valid never drops without transfer. Back-to-back transfers, one per cycle.
//  - done/err pulse in DONE (cycle after final transfer); busy falls with done. start ignored while busy.
//  - Exactly WIN*WIN*Nw*Nw transfers, Nw = (img_edge+1-WIN)/STRIDE + 1.
// CONFIGURATION
//  WAG_STRIDE_EN defined: extra port stride in 3 (1..7, 0 treated as 1), captured on start.
//  Not defined: no stride port, STRIDE fixed at 1. All other behaviour identical.
// STRUCTURE
//  Package wag_pkg: FSM state enum (IDLE/LOAD/EMIT/DONE), localparam function for WPP and shift.
//  Sub-module wag_wrap_cnt: parametric counter with step, limit, wrap flag; instanced for dc, dr,
//  c, r. Top holds FSM, address adders and output register.
// TESTING
//  1. WIN=3,WPP=64,base=0x100,edge=3,ready=1 -> 36 addrs; 0x100,0x140,0x180,0x200..; tap_last at
//     0x380 (win0); win1 starts 0x140; final 0x4C0; done+busy low next cycle.
//  2. Same, addr_ready low 5 cycles mid-window -> addr/tap_last held, no tap lost or duplicated.
//  3. edge=1 (2x2 < WIN) -> no addr_valid, done&err pulse 2 cycles after start.
//  4. WAG_STRIDE_EN, stride=2, edge=4 -> windows at (0,0),(0,2),(2,0),(2,2); 36 addrs.
//  5. rst high mid-sweep -> all outputs 0 next cycle, no done; new start runs full sweep cleanly.
//  6. base=0xFFFFFC0, edge=2 -> addresses wrap mod 2^28; start asserted while busy ignored.

Source files
------------

// File: rtl/win_addr_gen_pkg.sv
// rtl/win_addr_gen_pkg.sv - shared types and helper functions for the window address generator
package wag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } wag_state_e;

  localparam int STRIDE_W = 3;

  function automatic int wag_wpp(input int pix_bits, input int word_len);
    return pix_bits / word_len;
  endfunction

  // Words per pixel is a power of two, so pixel steps become a left shift.
  function automatic int wag_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/win_addr_gen_if.sv
// rtl/win_addr_gen_if.sv - tap address stream toward the DDR read requester
interface win_addr_gen_if #(
  parameter int ADDR_W = 28
);
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              tap_last;

  modport master (output addr, addr_valid, tap_last, input addr_ready);
  modport slave  (input addr, addr_valid, tap_last, output addr_ready);
endinterface

// File: rtl/win_addr_gen_wrap_cnt.sv
// rtl/win_addr_gen_wrap_cnt.sv - stepping counter that wraps to zero past a runtime limit
module wag_wrap_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic         wrap
);
  logic [W-1:0] cnt;
  logic [W:0]   nxt;

  // wrap means the next step would leave the legal range, so it flags the final value.
  assign nxt  = {1'b0, cnt} + {1'b0, step};
  assign wrap = nxt > {1'b0, limit};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : nxt[W-1:0];
    end
  end
endmodule

// File: rtl/win_addr_gen.sv
// rtl/win_addr_gen.sv - WINxWIN window-sweep DDR tap address generator
// WAG_STRIDE_EN adds a runtime stride port; without it the stride is fixed at 1.
module win_addr_gen
  import wag_pkg::*;
#(
  parameter int WIN      = 3,
  parameter int WORD_LEN = 32,
  parameter int PIX_BITS = 2048,
  parameter int ADDR_W   = 28,
  parameter int EDGE_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [EDGE_W-1:0]   img_edge,
`ifdef WAG_STRIDE_EN
  input  logic [STRIDE_W-1:0] stride,
`endif
  win_addr_gen_if.master      bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int WPP = wag_wpp(PIX_BITS, WORD_LEN);
  localparam int SH  = wag_log2(WPP);
  localparam int CW  = EDGE_W + 4;

  localparam logic [ADDR_W-1:0] WPP_A   = ADDR_W'(WPP);
  localparam logic [EDGE_W:0]   WIN_E   = (EDGE_W + 1)'(WIN);
  localparam logic [CW-1:0]     ONE_C   = CW'(1);
  localparam logic [CW-1:0]     TAPLIM  = CW'(WIN - 1);
  localparam logic [CW-1:0]     WIN_C   = CW'(WIN);

  wag_state_e state, state_n;

  logic [ADDR_W-1:0]   base_q;
  logic [EDGE_W-1:0]   edge_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [STRIDE_W-1:0] stride_in;
  logic                err_q;

  logic [ADDR_W-1:0] row_pitch, stride_pitch, col_step;
  logic [ADDR_W-1:0] r_base, win_base, row_base, addr_q;

  logic [EDGE_W:0]   edge_p1;
  logic [ADDR_W-1:0] pitch_c, spitch_c, cstep_c;
  logic [CW-1:0]     lim_pos, stride_c;
  logic              too_small;

  logic load, emit, xfer;
  logic dc_wrap, dr_wrap, c_wrap, r_wrap;
  logic last_tap, last_win;

`ifdef WAG_STRIDE_EN
  assign stride_in = (stride == '0) ? STRIDE_W'(1) : stride;
`else
  assign stride_in = STRIDE_W'(1);
`endif

  assign edge_p1   = {1'b0, edge_q} + (EDGE_W + 1)'(1);
  assign too_small = edge_p1 < WIN_E;
  assign lim_pos   = CW'(edge_p1) - WIN_C;
  assign stride_c  = CW'(stride_q);

  // Pitches come from shifts and a 3-term shift-add of the stride, no multiplier.
  assign pitch_c  = ADDR_W'(edge_p1) << SH;
  assign spitch_c = (stride_q[0] ? pitch_c : '0)
                  + (stride_q[1] ? (pitch_c << 1) : '0)
                  + (stride_q[2] ? (pitch_c << 2) : '0);
  assign cstep_c  = ADDR_W'(stride_q) << SH;

  assign load     = (state == ST_LOAD);
  assign emit     = (state == ST_EMIT);
  assign xfer     = emit && bus.addr_ready;
  assign last_tap = dc_wrap && dr_wrap;
  assign last_win = c_wrap && r_wrap;

  wag_wrap_cnt #(.W(CW)) u_dc (
    .clk(clk), .rst(rst), .clr(load), .en(xfer),
    .step(ONE_C), .limit(TAPLIM), .wrap(dc_wrap)
  );
  wag_wrap_cnt #(.W(CW)) u_dr (
    .clk(clk), .rst(rst), .clr(load), .en(xfer && dc_wrap),
    .step(ONE_C), .limit(TAPLIM), .wrap(dr_wrap)
  );
  wag_wrap_cnt #(.W(CW)) u_c (
    .clk(clk), .rst(rst), .clr(load), .en(xfer && last_tap),
    .step(stride_c), .limit(lim_pos), .wrap(c_wrap)
  );
  wag_wrap_cnt #(.W(CW)) u_r (
    .clk(clk), .rst(rst), .clr(load), .en(xfer && last_tap && c_wrap),
    .step(stride_c), .limit(lim_pos), .wrap(r_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_LOAD;
      ST_LOAD: state_n = too_small ? ST_DONE : ST_EMIT;
      ST_EMIT: if (xfer && last_tap && last_win) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Address walk: r_base = window row origin, win_base = window origin,
  // row_base = current tap row origin; addr_q advances only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= '0;
      edge_q       <= '0;
      stride_q     <= '0;
      err_q        <= 1'b0;
      row_pitch    <= '0;
      stride_pitch <= '0;
      col_step     <= '0;
      r_base       <= '0;
      win_base     <= '0;
      row_base     <= '0;
      addr_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            edge_q   <= img_edge;
            stride_q <= stride_in;
          end
        end
        ST_LOAD: begin
          row_pitch    <= pitch_c;
          stride_pitch <= spitch_c;
          col_step     <= cstep_c;
          err_q        <= too_small;
          r_base       <= base_q;
          win_base     <= base_q;
          row_base     <= base_q;
          addr_q       <= base_q;
        end
        ST_EMIT: begin
          if (xfer) begin
            if (!dc_wrap) begin
              addr_q <= addr_q + WPP_A;
            end else if (!dr_wrap) begin
              row_base <= row_base + row_pitch;
              addr_q   <= row_base + row_pitch;
            end else if (!c_wrap) begin
              win_base <= win_base + col_step;
              row_base <= win_base + col_step;
              addr_q   <= win_base + col_step;
            end else if (!r_wrap) begin
              r_base   <= r_base + stride_pitch;
              win_base <= r_base + stride_pitch;
              row_base <= r_base + stride_pitch;
              addr_q   <= r_base + stride_pitch;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = emit;
  assign bus.tap_last   = emit && last_tap;
  assign busy           = load || emit;
  assign done           = (state == ST_DONE);
  assign err            = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_win_addr_gen.sv
// tb/tb_win_addr_gen.sv - table-driven self-checking bench for win_addr_gen
// Define WAG_STRIDE_EN to also exercise the stride port.
module tb_win_addr_gen;

  localparam int WIN = 3;
  localparam int WPP = 64;

  typedef struct {
    logic [27:0] base;
    logic [5:0]  img_e;
    logic [2:0]  strd;
    int          stall_at;
    bit          poke;
    int          exp_n;
    logic [27:0] exp_last;
    bit          exp_err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [27:0] base_addr;
  logic [5:0]  img_edge;
`ifdef WAG_STRIDE_EN
  logic [2:0]  stride;
`endif
  logic        busy, done, err;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  win_addr_gen_if #(.ADDR_W(28)) bus ();

  win_addr_gen #(
    .WIN(WIN), .WORD_LEN(32), .PIX_BITS(2048), .ADDR_W(28), .EDGE_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .img_edge(img_edge),
`ifdef WAG_STRIDE_EN
    .stride(stride),
`endif
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [27:0] b, input logic [5:0] e, input logic [2:0] s,
                              input int st, input bit pk, input int n, input logic [27:0] la,
                              input bit er);
    vec_t v;
    v.base = b; v.img_e = e; v.strd = s; v.stall_at = st; v.poke = pk;
    v.exp_n = n; v.exp_last = la; v.exp_err = er;
    return v;
  endfunction

  // Reference address of the k-th transfer, straight from the row/column formula.
  function automatic logic [27:0] model_addr(input logic [27:0] b, input int e, input int s,
                                             input int nw, input int k);
    int tap, w, r, c;
    if (nw == 0) return 28'h0;
    tap = k % (WIN * WIN);
    w   = k / (WIN * WIN);
    r   = (w / nw) * s + tap / WIN;
    c   = (w % nw) * s + tap % WIN;
    return b + 28'((r * (e + 1) + c) * WPP);
  endfunction

  task automatic run_sweep(input vec_t v);
    int n, cyc, stall, first_v, last_x, done_c, s, nw;
    logic [27:0] last_a;
    logic        err_seen;
    n = 0; cyc = 0; stall = 0; first_v = -1; last_x = -1; done_c = -1;
    last_a = '0; err_seen = 1'b0;
    s  = (v.strd == 3'd0) ? 1 : int'(v.strd);
    nw = (int'(v.img_e) + 1 >= WIN) ? (int'(v.img_e) + 1 - WIN) / s + 1 : 0;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; img_edge = v.img_e;
`ifdef WAG_STRIDE_EN
    stride = v.strd;
`endif
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (done_c < 0 && cyc < 3000) begin
      bus.addr_ready = !(n == v.stall_at && stall < 5);
      if (!bus.addr_ready) stall++;
      if (v.poke && cyc == 6) begin
        start = 1'b1; base_addr = 28'h0ABCDE0;
      end else begin
        start = 1'b0;
      end
      if (bus.addr_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("addr", 32'(bus.addr), 32'(model_addr(v.base, int'(v.img_e), s, nw, n)));
        chk("tap_last", 32'(bus.tap_last), 32'((n % (WIN * WIN)) == WIN * WIN - 1));
        if (bus.addr_ready) begin
          last_a = bus.addr; last_x = cyc; n++;
        end
      end
      if (done) begin
        done_c = cyc; err_seen = err;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (done_c < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done_c >= 0), 32'd1);
    chk("xfer_count", 32'(n), 32'(v.exp_n));
    chk("err", 32'(err_seen), 32'(v.exp_err));
    if (v.exp_n > 0) begin
      chk("first_valid_cycle", 32'(first_v), 32'd2);
      chk("last_addr", 32'(last_a), 32'(v.exp_last));
      chk("done_latency", 32'(done_c), 32'(last_x + 1));
    end else begin
      chk("err_done_cycle", 32'(done_c), 32'd2);
      chk("err_no_valid", 32'(first_v), 32'hFFFF_FFFF);
    end
    @(negedge clk);
    chk("done_one_pulse", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("idle_valid", 32'(bus.addr_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    bus.addr_ready = 1'b1;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; base_addr = '0; img_edge = '0; bus.addr_ready = 1'b1;
`ifdef WAG_STRIDE_EN
    stride = 3'd1;
`endif
    vecs.push_back(mk(28'h100,     6'd3, 3'd1, -1, 1'b0,  36, 28'h4C0, 1'b0));
    vecs.push_back(mk(28'h100,     6'd3, 3'd1,  4, 1'b0,  36, 28'h4C0, 1'b0));
    vecs.push_back(mk(28'h100,     6'd1, 3'd1, -1, 1'b0,   0, 28'h000, 1'b1));
    vecs.push_back(mk(28'hFFFFFC0, 6'd2, 3'd1, -1, 1'b1,   9, 28'h1C0, 1'b0));
    vecs.push_back(mk(28'h020,     6'd5, 3'd1, 13, 1'b0, 144, 28'h8E0, 1'b0));
    vecs.push_back(mk(28'h000,     6'd0, 3'd1, -1, 1'b0,   0, 28'h000, 1'b1));
`ifdef WAG_STRIDE_EN
    vecs.push_back(mk(28'h000,     6'd4, 3'd2, -1, 1'b0,  36, 28'h600, 1'b0));
    vecs.push_back(mk(28'h000,     6'd3, 3'd0, -1, 1'b0,  36, 28'h3C0, 1'b0));
    vecs.push_back(mk(28'h000,     6'd4, 3'd3,  2, 1'b0,   9, 28'h300, 1'b0));
`endif

    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_tap_last", 32'(bus.tap_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_sweep(vecs[i]);

    // Abort a sweep with reset, then prove a fresh start runs clean.
    @(negedge clk);
    start = 1'b1; base_addr = 28'h100; img_edge = 6'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_valid_before_rst", 32'(bus.addr_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_addr", 32'(bus.addr), 32'd0);
    chk("abort_valid", 32'(bus.addr_valid), 32'd0);
    chk("abort_tap_last", 32'(bus.tap_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || bus.addr_valid || busy) seen = 1'b1;
    end
    chk("quiet_after_abort", 32'(seen), 32'd0);
    run_sweep(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
